// File: rtl/mem_access_unit_if.sv
// Core/memory-side bundle for mem_access_unit: load/store request from the
// core, load result and stall back to it, and the data-memory port.
interface mem_access_unit_if #(
  parameter int ADDR_W = 6
);
  logic              mem_read;
  logic              mem_write;
  logic [1:0]        size;
  logic              load_unsigned;
  logic [31:0]       byte_addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              stall;
  logic              misaligned;
  logic              addr_fault;
  logic              dm_we;
  logic              dm_re;
  logic [ADDR_W-1:0] dm_addr;
  logic [31:0]       dm_wd;
  logic [31:0]       dm_rd;

  // The access unit itself.
  modport slave (
    input  mem_read, mem_write, size, load_unsigned, byte_addr, wdata, dm_rd,
    output rdata, stall, misaligned, addr_fault, dm_we, dm_re, dm_addr, dm_wd
  );

  // Core plus data memory around the unit.
  modport master (
    output mem_read, mem_write, size, load_unsigned, byte_addr, wdata, dm_rd,
    input  rdata, stall, misaligned, addr_fault, dm_we, dm_re, dm_addr, dm_wd
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store unit in front of a 2**ADDR_W x 32 data memory: subword loads with
// extension, sb/sh as a two-cycle read-modify-write, alignment/range faults.
module mem_access_unit #(
  parameter int ADDR_W = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_access_unit_if.slave   bus
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_MERGE = 1'b1
  } state_t;

  state_t              r_state;
  logic [ADDR_W+1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic [1:0]          r_size;
  logic [31:0]         r_old;

  logic [ADDR_W-1:0]   w_index;
  logic                w_req;
  logic                w_is_half;
  logic                w_is_word;
  logic                w_addr_fault;
  logic                w_misaligned;
  logic                w_fault;
  logic                w_sub_store;

  function automatic logic [31:0] f_load_extract(
    input logic [31:0] word,
    input logic [1:0]  off,
    input logic [1:0]  sz,
    input logic        uns
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (sz)
      2'b00:   res = uns ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   res = uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: res = word;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] f_store_merge(
    input logic [31:0] old,
    input logic [31:0] wd,
    input logic [1:0]  off,
    input logic [1:0]  sz
  );
    logic [31:0] res;
    res = old;
    case (sz)
      2'b00: res[{off, 3'b000} +: 8] = wd[7:0];
      2'b01: begin
        if (off[1]) begin
          res[31:16] = wd[15:0];
        end else begin
          res[15:0] = wd[15:0];
        end
      end
      default: res = wd;
    endcase
    return res;
  endfunction

  // Request decode and fault detection on the live core inputs.
  always_comb begin
    w_index      = bus.byte_addr[ADDR_W+1:2];
    w_req        = bus.mem_read | bus.mem_write;
    w_is_half    = (bus.size == 2'b01);
    w_is_word    = bus.size[1];
    w_addr_fault = w_req & (|bus.byte_addr[31:ADDR_W+2]);
    w_misaligned = w_req & ((w_is_half & bus.byte_addr[0]) |
                            (w_is_word & (bus.byte_addr[1:0] != 2'b00)));
    w_fault      = w_addr_fault | w_misaligned;
    w_sub_store  = bus.mem_write & ~w_fault & ~w_is_word;
  end

  // State and read-modify-write capture; a reset in MERGE discards the store.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_wdata <= 32'd0;
      r_size  <= 2'b00;
      r_old   <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_sub_store) begin
            r_old   <= bus.dm_rd;
            r_addr  <= bus.byte_addr[ADDR_W+1:0];
            r_wdata <= bus.wdata;
            r_size  <= bus.size;
            r_state <= S_MERGE;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_MERGE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Output steering; loads stay combinational for zero wait states.
  always_comb begin
    bus.rdata      = 32'd0;
    bus.stall      = 1'b0;
    bus.misaligned = 1'b0;
    bus.addr_fault = 1'b0;
    bus.dm_we      = 1'b0;
    bus.dm_re      = 1'b0;
    bus.dm_addr    = w_index;
    bus.dm_wd      = 32'd0;
    if (!rst_n) begin
      bus.dm_addr = w_index;
    end else if (r_state == S_MERGE) begin
      bus.dm_we   = 1'b1;
      bus.dm_addr = r_addr[ADDR_W+1:2];
      bus.dm_wd   = f_store_merge(r_old, r_wdata, r_addr[1:0], r_size);
    end else begin
      bus.misaligned = w_misaligned;
      bus.addr_fault = w_addr_fault;
      if (w_fault) begin
        bus.dm_we = 1'b0;
      end else if (bus.mem_write) begin
        // Store has priority over a simultaneous load; rdata stays 0.
        if (w_is_word) begin
          bus.dm_we = 1'b1;
          bus.dm_wd = bus.wdata;
        end else begin
          bus.dm_re = 1'b1;
          bus.stall = 1'b1;
        end
      end else if (bus.mem_read) begin
        bus.dm_re = 1'b1;
        bus.rdata = f_load_extract(bus.dm_rd, bus.byte_addr[1:0], bus.size,
                                   bus.load_unsigned);
      end else begin
        bus.dm_re = 1'b0;
      end
    end
  end

endmodule
